// File: rtl/lsu_pkg.sv
// Shared LSU definitions: FSM states, RV32I load/store funct3 codes, legality helper.
// Latency: none (types and constants only).
// Backpressure: none.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // An op is legal when funct3 names a real access for its direction
    // and the address is naturally aligned for that access size.
    function automatic logic op_legal(input logic is_st, input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (is_st) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
        end
        if (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) begin
            ok = 1'b0;
        end
        if ((f3 == F3_W) && (off != 2'b00)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts/extends load data and packs store data with byte enables.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] sd,
    output logic [31:0] wd,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: pick the addressed lane and sign/zero-extend it.
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        wd       = rdata;
        case (funct3)
            F3_B:    wd = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   wd = {24'h000000, byte_sel};
            F3_H:    wd = {{16{half_sel[15]}}, half_sel};
            F3_HU:   wd = {16'h0000, half_sel};
            default: wd = rdata;
        endcase
    end

    // Store path: replicate the datum across all lanes, enable only the addressed ones.
    always_comb begin
        wdata = sd;
        wstrb = 4'b1111;
        case (funct3)
            F3_B: begin
                wdata = {4{sd[7:0]}};
                wstrb = 4'b0001 << off;
            end
            F3_H: begin
                wdata = {2{sd[15:0]}};
                wstrb = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                wdata = sd;
                wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one RV32I load or store per start pulse, load result written to the regfile.
// Latency: start edge N -> mem_req in N+1, done/rf_write in N+2 with zero-wait memory.
// Backpressure: holds mem_req and payload until mem_ready; busy stalls the core; TIMEOUT bounds the wait.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        rf_write,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    lsu_state_t    state;
    lsu_state_t    state_nxt;
    logic          op_store;
    logic [2:0]    op_f3;
    logic [31:0]   op_addr;
    logic [31:0]   op_sd;
    logic [4:0]    op_rd;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   load_wd;
    logic [31:0]   pack_wdata;
    logic [3:0]    pack_wstrb;
    logic          load_wb;

    lsu_align u_align (
        .funct3 (op_f3),
        .off    (op_addr[1:0]),
        .rdata  (mem_rdata),
        .sd     (op_sd),
        .wd     (load_wd),
        .wdata  (pack_wdata),
        .wstrb  (pack_wstrb)
    );

    assign cnt_inc = cnt + CW'(1);
    // Only loads to a real register produce a writeback; x0 writes are suppressed.
    assign load_wb = !op_store && (op_rd != 5'd0);

    // State, operand capture, wait counter and the held writeback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_store <= 1'b0;
            op_f3    <= 3'd0;
            op_addr  <= 32'd0;
            op_sd    <= 32'd0;
            op_rd    <= 5'd0;
            cnt      <= '0;
            rf_wa    <= 5'd0;
            rf_wd    <= 32'd0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                op_store <= is_store;
                op_f3    <= funct3;
                op_addr  <= addr;
                op_sd    <= store_data;
                op_rd    <= rd;
            end
            cnt <= (state == REQ) ? cnt_inc : '0;
            // rf_wd only moves when a write is about to be issued, so it holds otherwise.
            if ((state == REQ) && mem_ready && load_wb) begin
                rf_wa <= op_rd;
                rf_wd <= load_wd;
            end
        end
    end

    // Next-state decode: legality check at launch, ready/timeout race in REQ.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = op_legal(is_store, funct3, addr[1:0]) ? REQ : ERR;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_nxt = RESP;
                end else if ((TIMEOUT != 0) && (cnt_inc == TMAX)) begin
                    state_nxt = ERR;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode from state; bus payload comes from the captured operands so it is stable in REQ.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == RESP);
        err       = (state == ERR);
        mem_req   = (state == REQ);
        mem_we    = (state == REQ) && op_store;
        mem_addr  = {op_addr[31:2], 2'b00};
        mem_wdata = pack_wdata;
        mem_wstrb = ((state == REQ) && op_store) ? pack_wstrb : 4'b0000;
        rf_write  = (state == RESP) && load_wb;
    end

endmodule
